// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order word requests to a
// variable-latency instruction memory and buffers returned words with their PCs.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pause,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     inst_out
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {FETCH, FLUSH} state_t;

  state_t          state;
  logic            started;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] addr_q [DEPTH];
  logic [AW-1:0]   aq_wr, aq_rd;
  logic [XLEN-1:0] buf_pc [DEPTH];
  logic [31:0]     buf_inst [DEPTH];
  logic [AW-1:0]   bf_wr, bf_rd;
  logic [CW-1:0]   outstanding, occupancy, drop;

  logic            req_fire, pop;
  logic [CW-1:0]   acc_c, resp_c, pop_c, in_use, drop_n;

  assign in_use         = outstanding + occupancy;
  // Held low for the first cycle out of reset so the request port starts quiet.
  assign imem_req_valid = started && (state == FETCH) && (in_use < DEPTH_C);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign inst_valid = (occupancy != '0);
  assign pc_out     = inst_valid ? buf_pc[bf_rd]   : '0;
  assign inst_out   = inst_valid ? buf_inst[bf_rd] : NOP;
  assign pop        = inst_valid & ~pause;

  assign acc_c  = CW'(req_fire);
  assign resp_c = CW'(imem_resp_valid);
  assign pop_c  = CW'(pop);

  // A same-cycle response retires one in-flight request and is itself discarded.
  always_comb begin
    drop_n = drop;
    if (state == FETCH)
      drop_n = outstanding + acc_c - resp_c;
    else if (imem_resp_valid)
      drop_n = drop - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FETCH;
      started     <= 1'b0;
      pc          <= RESET_PC;
      aq_wr       <= '0;
      aq_rd       <= '0;
      bf_wr       <= '0;
      bf_rd       <= '0;
      outstanding <= '0;
      occupancy   <= '0;
      drop        <= '0;
    end else begin
      started <= 1'b1;
      if (redirect || state == FLUSH) begin
        drop  <= drop_n;
        state <= (drop_n != '0) ? FLUSH : FETCH;
      end
      if (redirect) begin
        pc          <= redirect_pc & ~XLEN'(3);
        aq_wr       <= '0;
        aq_rd       <= '0;
        bf_wr       <= '0;
        bf_rd       <= '0;
        outstanding <= '0;
        occupancy   <= '0;
      end else if (state == FETCH) begin
        if (req_fire) begin
          addr_q[aq_wr] <= pc;
          aq_wr         <= aq_wr + 1'b1;
          pc            <= pc + XLEN'(4);
        end
        if (imem_resp_valid) begin
          buf_pc[bf_wr]   <= addr_q[aq_rd];
          buf_inst[bf_wr] <= imem_resp_data;
          bf_wr           <= bf_wr + 1'b1;
          aq_rd           <= aq_rd + 1'b1;
        end
        if (pop)
          bf_rd <= bf_rd + 1'b1;
        outstanding <= outstanding + acc_c - resp_c;
        occupancy   <= occupancy + resp_c - pop_c;
      end
    end
  end

  // Responses only ever answer an in-flight request, and never land on a full buffer.
  assert property (@(posedge clock) disable iff (reset)
    (state == FETCH && !redirect && imem_resp_valid) |->
      (outstanding != '0 && occupancy != DEPTH_C));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model with configurable latency/ready,
// expected PC stream queued by stimulus, monitor checks every consumed instruction.
module tb_fetch_unit;
  logic        clock = 1'b0;
  logic        reset, pause, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] pc_out, inst_out;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clock(clock), .reset(reset), .pause(pause), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .pc_out(pc_out), .inst_out(inst_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[25:2], 8'h93};
  endfunction

  // Memory model: in-order responses, latency drawn from [lat_min, lat_max].
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t pend[$];
  bit   rnd_ready = 1'b0;
  int   lat_min = 1;
  int   lat_max = 1;

  initial begin
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
  end

  always begin
    @(negedge clock);
    #1;
    if (reset) begin
      pend.delete();
      imem_resp_valid = 1'b0;
      imem_req_ready  = 1'b1;
    end else begin
      if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = inst_of(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
      end
      imem_req_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (imem_req_valid && imem_req_ready) begin
        req_t r;
        r.addr = imem_req_addr;
        r.due  = cyc + 1 + int'($urandom_range(lat_max, lat_min));
        pend.push_back(r);
      end
    end
  end

  // Monitor: each instruction the pipeline consumes must be the next expected PC.
  logic [31:0] exp_q[$];

  always begin
    @(negedge clock);
    #1;
    if (!reset && !redirect && inst_valid && !pause) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", pc_out, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", pc_out, e);
        chk("sb_inst", inst_out, inst_of(e));
      end
    end
  end

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_drain(input int budget, input bit rnd_pause);
    int n = 0;
    forever begin
      @(negedge clock);
      n++;
      if (exp_q.size() == 0 || n >= budget) break;
      pause = rnd_pause ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    pause = 1'b1;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    pause = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;

    // 1: reset values, then in-order streaming with 1-cycle latency
    repeat (2) @(negedge clock);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_inst_out", inst_out, NOP);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    push_seq(32'h0, 8);
    reset = 1'b0;
    wait_drain(100, 1'b0);

    // 2: pause five cycles; head held, fetch stops at capacity
    repeat (2) @(negedge clock);
    repeat (3) begin
      @(negedge clock);
      chk("pause_pc_held", pc_out, 32'h20);
      chk("pause_inst_held", inst_out, inst_of(32'h20));
    end
    chk("pause_req_valid", 32'(imem_req_valid), 32'd0);
    chk("pause_inst_valid", 32'(inst_valid), 32'd1);
    push_seq(32'h20, 8);
    pause = 1'b0;
    wait_drain(100, 1'b0);

    // 3: redirect with two requests outstanding, latency 4
    lat_min = 4;
    lat_max = 4;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    pause = 1'b0;
    repeat (3) @(negedge clock);
    chk("t3_req_valid_full", 32'(imem_req_valid), 32'd0);
    chk("t3_inst_valid", 32'(inst_valid), 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    push_seq(32'h100, 4);
    @(negedge clock);
    redirect = 1'b0;
    chk("t3_flush_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t3_flush_addr", imem_req_addr, 32'h100);
    @(negedge clock);
    chk("t3_flush_req_valid2", 32'(imem_req_valid), 32'd0);
    wait_drain(200, 1'b0);

    // 4: misaligned redirect target while paused with a full buffer
    repeat (10) @(negedge clock);
    chk("t4_full_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t4_full_inst_valid", 32'(inst_valid), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h103;
    @(negedge clock);
    redirect = 1'b0;
    chk("t4_flushed_inst_valid", 32'(inst_valid), 32'd0);
    chk("t4_aligned_addr", imem_req_addr, 32'h100);
    chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
    push_seq(32'h100, 4);
    pause = 1'b0;
    wait_drain(200, 1'b0);

    // 5: random ready, latency 1-4, random pause
    rnd_ready = 1'b1;
    lat_min = 1;
    lat_max = 4;
    @(negedge clock);
    redirect = 1'b1;
    redirect_pc = 32'h2000;
    push_seq(32'h2000, 40);
    @(negedge clock);
    redirect = 1'b0;
    pause = 1'b0;
    wait_drain(1500, 1'b1);

    // 6: reset with two requests outstanding
    rnd_ready = 1'b0;
    lat_min = 4;
    lat_max = 4;
    repeat (10) @(negedge clock);
    redirect = 1'b1;
    redirect_pc = 32'h300;
    @(negedge clock);
    redirect = 1'b0;
    repeat (2) @(negedge clock);
    chk("t6_two_outstanding", 32'(imem_req_valid), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("t6_inst_valid", 32'(inst_valid), 32'd0);
    chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t6_pc_reset", imem_req_addr, 32'h0);
    chk("t6_pc_out", pc_out, 32'h0);
    reset = 1'b0;
    push_seq(32'h0, 8);
    pause = 1'b0;
    wait_drain(200, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
